// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code enum, last legal op code and datapath width.
package alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1001
    } alu_op_e;

    localparam logic [3:0] ALU_OP_LAST = 4'b1001;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU; op codes above ALU_OP_LAST yield result 0 with o_err set.
import alu_pkg::*;

module alu (
    input  logic [3:0]       i_op,
    input  logic [ALU_W-1:0] i_a,
    input  logic [ALU_W-1:0] i_b,
    output logic [ALU_W-1:0] o_result,
    output logic             o_zero,
    output logic             o_err
);

    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SLT:  o_result = ($signed(i_a) < $signed(i_b)) ? ALU_W'(1) : '0;
            ALU_SLTU: o_result = (i_a < i_b) ? ALU_W'(1) : '0;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            default:  o_result = '0;
        endcase
    end

    assign o_err  = (i_op > ALU_OP_LAST);
    assign o_zero = (o_result == '0);

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between NUM_REQ requesters with a single result slot.
// Optional grant locking is compiled in with `define ALU_ARB_LOCK_EN.
import alu_pkg::*;

module alu_share_arb #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*ALU_W-1:0] req_a,
    input  logic [NUM_REQ*ALU_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]     req_op,
    input  logic [NUM_REQ-1:0]       req_lock,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [ALU_W-1:0]         rsp_result,
    output logic                     rsp_zero,
    output logic                     rsp_err,
    output logic [ID_W-1:0]          rsp_id
);

    logic [ID_W-1:0]    r_ptr;
    logic               r_full;
    logic [NUM_REQ-1:0] w_rr_oh;
    logic [ID_W-1:0]    w_rr_id;
    logic [NUM_REQ-1:0] w_win_oh;
    logic [ID_W-1:0]    w_win_id;
    logic               w_win_vld;
    logic               w_slot_free;
    logic               w_hs;
    logic [ALU_W-1:0]   w_a, w_b, w_alu_res;
    logic [3:0]         w_op;
    logic               w_alu_zero, w_alu_err;

    assign w_slot_free = !r_full || (|(rsp_valid & rsp_ready));

    // Candidates visited from farthest to nearest so the nearest valid one (ptr+1) wins last.
    always_comb begin
        w_rr_oh = '0;
        w_rr_id = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((((int'(r_ptr) + k) % NUM_REQ) == i) && req_valid[i]) begin
                    w_rr_oh    = '0;
                    w_rr_oh[i] = 1'b1;
                    w_rr_id    = ID_W'(i);
                end
            end
        end
    end

`ifdef ALU_ARB_LOCK_EN
    logic               r_locked;
    logic [NUM_REQ-1:0] r_lock_oh;
    logic [ID_W-1:0]    r_lock_id;

    assign w_win_oh = r_locked ? (r_lock_oh & req_valid) : w_rr_oh;
    assign w_win_id = r_locked ? r_lock_id : w_rr_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked  <= 1'b0;
            r_lock_oh <= '0;
            r_lock_id <= '0;
        end else if (w_hs) begin
            r_locked  <= |(req_lock & w_win_oh);
            r_lock_oh <= w_win_oh;
            r_lock_id <= w_win_id;
        end else if (r_locked && w_slot_free && !(|(req_valid & r_lock_oh))) begin
            r_locked <= 1'b0;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^req_lock;
    assign w_win_oh      = w_rr_oh;
    assign w_win_id      = w_rr_id;
`endif

    assign w_win_vld = |w_win_oh;
    assign w_hs      = w_win_vld && w_slot_free && rst_n;

    always_comb begin
        w_a  = '0;
        w_b  = '0;
        w_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_a  = req_a[i*ALU_W +: ALU_W];
                w_b  = req_b[i*ALU_W +: ALU_W];
                w_op = req_op[i*4 +: 4];
            end
        end
    end

    alu u_alu (
        .i_op     (w_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .o_result (w_alu_res),
        .o_zero   (w_alu_zero),
        .o_err    (w_alu_err)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ports
            assign req_ready[gi] = w_hs && w_win_oh[gi];
            assign rsp_valid[gi] = r_full && (rsp_id == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= ID_W'(NUM_REQ - 1);
            r_full     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_id     <= '0;
        end else if (w_hs) begin
            r_ptr      <= w_win_id;
            r_full     <= 1'b1;
            rsp_result <= w_alu_res;
            rsp_zero   <= w_alu_zero;
            rsp_err    <= w_alu_err;
            rsp_id     <= w_win_id;
        end else if (w_slot_free) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb (NUM_REQ=2); lock scenario depends on ALU_ARB_LOCK_EN.
module tb_alu_share_arb;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [NUM_REQ*32-1:0]  req_a;
    logic [NUM_REQ*32-1:0]  req_b;
    logic [NUM_REQ*4-1:0]   req_op;
    logic [NUM_REQ-1:0]     req_lock;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [NUM_REQ-1:0]     rsp_ready;
    logic [31:0]            rsp_result;
    logic                   rsp_zero;
    logic                   rsp_err;
    logic [ID_W-1:0]        rsp_id;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_lock   (req_lock),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .rsp_id     (rsp_id)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b, input logic lk);
        req_valid[i]      = v;
        req_op[i*4 +: 4]  = op;
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_lock[i]       = lk;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{4'b0001, 32'h1,        32'h4,        32'h10,       1'b0, 1'b0};
        tbl[1] = '{4'b0001, 32'h1,        32'h24,       32'h10,       1'b0, 1'b0};
        tbl[2] = '{4'b0010, 32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0};
        tbl[3] = '{4'b0011, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
        tbl[4] = '{4'b0101, 32'h80000000, 32'h4,        32'h08000000, 1'b0, 1'b0};
        tbl[5] = '{4'b0111, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0};
        tbl[6] = '{4'b1000, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[7] = '{4'b0000, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0};
        tbl[8] = '{4'b1100, 32'h3,        32'h4,        32'h0,        1'b1, 1'b1};
        tbl[9] = '{4'b1001, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1'b0};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        req_lock = '0; rsp_ready = '0;
        set_req(0, 1'b1, 4'b0000, 32'd5, 32'd7, 1'b0);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_zero", 32'(rsp_zero), 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        chk("rst_id", 32'(rsp_id), 32'h0);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        $display("txn: first ADD 5+7 on requester 0");
        chk("first_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        chk("first_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("first_result", rsp_result, 32'd12);
        chk("first_zero", 32'(rsp_zero), 32'h0);
        chk("first_id", 32'(rsp_id), 32'h0);
        rsp_ready = 2'b11;
        tick();
        chk("first_drained", 32'(rsp_valid), 32'h0);

        // Alternation: pointer now 0, so requester 1 leads.
        set_req(0, 1'b1, 4'b0100, 32'hF0, 32'hFF, 1'b0);
        set_req(1, 1'b1, 4'b0110, 32'hF0, 32'h0F, 1'b0);
        for (int k = 0; k < 4; k++) begin
            int g;
            g = (k % 2 == 0) ? 1 : 0;
            #1;
            $display("txn: alternate grant %0d expect requester %0d", k, g);
            chk("alt_ready", 32'(req_ready), 32'(1 << g));
            tick();
            chk("alt_rsp_valid", 32'(rsp_valid), 32'(1 << g));
            chk("alt_result", rsp_result, (g == 1) ? 32'hFF : 32'h0F);
        end
        req_valid = '0;
        tick();

        for (int t = 0; t < 10; t++) begin
            set_req(0, 1'b1, tbl[t].op, tbl[t].a, tbl[t].b, 1'b0);
            #1;
            $display("txn: op %b a=%h b=%h", tbl[t].op, tbl[t].a, tbl[t].b);
            chk("op_ready", 32'(req_ready), 32'h1);
            tick();
            req_valid = '0;
            chk("op_result", rsp_result, tbl[t].res);
            chk("op_zero", 32'(rsp_zero), 32'(tbl[t].zero));
            chk("op_err", 32'(rsp_err), 32'(tbl[t].err));
            tick();
        end

        // Consumer stall on a requester 1 response.
        rsp_ready = '0;
        set_req(1, 1'b1, 4'b1000, 32'd9, 32'd9, 1'b0);
        #1;
        $display("txn: SUB 9-9 on requester 1 with stalled consumer");
        chk("stall_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        set_req(0, 1'b1, 4'b0000, 32'd2, 32'd3, 1'b0);
        for (int c = 0; c < 3; c++) begin
            rsp_ready = (c == 1) ? 2'b01 : 2'b00;
            #1;
            chk("stall_req_ready", 32'(req_ready), 32'h0);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'h2);
            chk("stall_result", rsp_result, 32'h0);
            chk("stall_zero", 32'(rsp_zero), 32'h1);
            tick();
        end
        rsp_ready = 2'b10;
        #1;
        chk("stall_refill_ready", 32'(req_ready), 32'h1);
        tick();
        chk("stall_refill_valid", 32'(rsp_valid), 32'h1);
        chk("stall_refill_result", rsp_result, 32'd5);
        req_valid = '0;
        rsp_ready = 2'b11;
        tick();

        // Reset while requester 1 response is pending.
        rsp_ready = '0;
        set_req(1, 1'b1, 4'b0000, 32'd1, 32'd1, 1'b0);
        tick();
        $display("txn: reset with requester 1 response pending");
        chk("rstmid_pending", 32'(rsp_valid), 32'h2);
        req_valid = 2'b11;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rstmid_req_ready", 32'(req_ready), 32'h0);
        chk("rstmid_result", rsp_result, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rstmid_prio0", 32'(req_ready), 32'h1);
        tick();
        chk("rstmid_id", 32'(rsp_id), 32'h0);

        // Reset with requester 0 pending: only a pointer reset lets 0 win again.
        $display("txn: reset with requester 0 response pending");
        rst_n = 1'b0;
        #1;
        chk("rstptr_rsp_valid", 32'(rsp_valid), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rstptr_prio0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        rsp_ready = 2'b11;
        tick();

        // Pointer is 0: requester 1 leads the lock scenario.
        set_req(0, 1'b1, 4'b0000, 32'd100, 32'd1, 1'b0);
`ifdef ALU_ARB_LOCK_EN
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 4'b0000, 32'(k), 32'd1, (k < 3) ? 1'b1 : 1'b0);
            #1;
            $display("txn: locked op %0d on requester 1", k);
            chk("lock_ready", 32'(req_ready), 32'h2);
            tick();
            chk("lock_id", 32'(rsp_id), 32'h1);
            chk("lock_result", rsp_result, 32'(k + 1));
        end
        #1;
        chk("lock_release", 32'(req_ready), 32'h1);
        tick();
        chk("lock_rel_result", rsp_result, 32'd101);
`else
        set_req(1, 1'b1, 4'b0000, 32'd7, 32'd1, 1'b1);
        #1;
        $display("txn: req_lock ignored, requester 1 then requester 0");
        chk("nolock_first", 32'(req_ready), 32'h2);
        tick();
        chk("nolock_first_res", rsp_result, 32'd8);
        #1;
        chk("nolock_second", 32'(req_ready), 32'h1);
        tick();
        chk("nolock_second_res", rsp_result, 32'd101);
`endif
        req_valid = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
